// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: one 1-bit cell plus a borrow flop, LSB first.
// State table:  IDLE | waiting for start ;  SHIFT | one bit per clock ;  DONE | one-cycle result pulse
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               br_q;
    logic [WIDTH-1:0]   diff_q;
    logic               borrow_q;

    logic               bit_d;
    logic               br_d;
    logic [WIDTH-1:0]   a_d;

    // The minuend register doubles as the result shift register: difference
    // bits enter at the MSB as operand bits leave from the LSB.
    always_comb begin
        bit_d = a_q[0] ^ b_q[0] ^ br_q;
        br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        a_d   = {bit_d, a_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        cnt_q   <= '0;
                        br_q    <= 1'b0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_q   <= a_d;
                    b_q   <= b_q >> 1;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        diff_q   <= a_d;
                        borrow_q <= br_d;
                        cnt_q    <= '0;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        cnt_q   <= '0;
                        br_q    <= 1'b0;
                        state_q <= S_SHIFT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = (state_q == S_SHIFT);
    assign done       = (state_q == S_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random checks for serial_sub_ctrl at WIDTH=8 and WIDTH=16.
module tb_serial_sub_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [7:0]  a8, b8, diff8;
    logic [15:0] a16, b16, diff16;
    logic        busy8, done8, bo8;
    logic        busy16, done16, bo16;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0]  prev_d8  = '0;
    logic        prev_b8  = 1'b0;
    logic [15:0] prev_d16 = '0;
    logic        prev_b16 = 1'b0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    serial_sub_ctrl #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bo16)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       br;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation; operands are scrambled during SHIFT to prove capture.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb);
        a8 = a; b8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("busy8", {busy8, done8}, 2'b10);
            chk("hold8", {bo8, diff8}, {prev_b8, prev_d8});
            a8 = 8'($urandom); b8 = 8'($urandom);
            tick();
        end
        chk("done8", {busy8, done8}, 2'b01);
        chk("res8", {bo8, diff8}, {eb, ed});
        prev_d8 = ed; prev_b8 = eb;
        tick();
        chk("idle8", {busy8, done8}, 2'b00);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] ed;
        logic        eb;
        ed = a - b;
        eb = (a < b);
        a16 = a; b16 = b; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("busy16", {busy16, done16}, 2'b10);
            chk("hold16", {bo16, diff16}, {prev_b16, prev_d16});
            a16 = 16'($urandom); b16 = 16'($urandom);
            tick();
        end
        chk("done16", {busy16, done16}, 2'b01);
        chk("res16", {bo16, diff16}, {eb, ed});
        prev_d16 = ed; prev_b16 = eb;
        tick();
        chk("idle16", {busy16, done16}, 2'b00);
    endtask

    initial begin
        vec_t tbl[7];
        logic [7:0] ra, rb;
        int seen;

        tbl = '{
            '{8'd200, 8'd55,  8'd145, 1'b0},
            '{8'd5,   8'd9,   8'd252, 1'b1},
            '{8'd0,   8'd255, 8'd1,   1'b1},
            '{8'd0,   8'd0,   8'd0,   1'b0},
            '{8'd255, 8'd0,   8'd255, 1'b0},
            '{8'd128, 8'd129, 8'd255, 1'b1},
            '{8'd255, 8'd255, 8'd0,   1'b0}
        };

        rst = 1'b1; start8 = 1'b1; start16 = 1'b1;
        a8 = 8'd7; b8 = 8'd3; a16 = '0; b16 = '0;
        tick(); tick();
        chk("rst_state8", {busy8, done8, bo8, diff8}, 11'd0);
        chk("rst_state16", {busy16, done16, bo16, diff16}, 19'd0);
        rst = 1'b0; start8 = 1'b0; start16 = 1'b0;
        tick(); tick();
        chk("idle_stay", {busy8, done8}, 2'b00);

        foreach (tbl[i]) run8(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].br);

        // start re-pulsed mid-SHIFT with new operands must be ignored
        a8 = 8'd200; b8 = 8'd55; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("mid_busy", {busy8, done8}, 2'b10);
            start8 = (i == 2 || i == 3);
            a8 = 8'd1; b8 = 8'd2;
            if (i > 3) begin a8 = 8'($urandom); b8 = 8'($urandom); end
            tick();
        end
        start8 = 1'b0;
        chk("mid_done", {busy8, done8}, 2'b01);
        chk("mid_res", {bo8, diff8}, {1'b0, 8'd145});
        prev_d8 = 8'd145; prev_b8 = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) seen++;
        end
        chk("mid_single", 32'(seen), 32'd0);

        // reset on the 4th SHIFT cycle aborts without a done pulse
        a8 = 8'd5; b8 = 8'd9; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        chk("rst4_busy", {busy8, done8}, 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst4_clear", {busy8, done8, bo8, diff8}, 11'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8 || diff8 != 8'd0) seen++;
        end
        chk("rst4_nodone", 32'(seen), 32'd0);
        prev_d8 = '0; prev_b8 = 1'b0;

        // start held high: results 9 cycles apart
        a8 = 8'd100; b8 = 8'd1; start8 = 1'b1;
        tick();
        a8 = 8'd77; b8 = 8'd200;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_busy1", {busy8, done8}, 2'b10);
            tick();
        end
        chk("b2b_done1", {busy8, done8}, 2'b01);
        chk("b2b_res1", {bo8, diff8}, {1'b0, 8'd99});
        a8 = 8'd1; b8 = 8'd2;
        tick();
        a8 = 8'd50; b8 = 8'd10;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_busy2", {busy8, done8}, 2'b10);
            chk("b2b_hold", {bo8, diff8}, {1'b0, 8'd99});
            tick();
        end
        chk("b2b_done2", {busy8, done8}, 2'b01);
        chk("b2b_res2", {bo8, diff8}, {1'b1, 8'd255});
        start8 = 1'b0;
        tick();
        chk("b2b_idle", {busy8, done8}, 2'b00);
        prev_d8 = 8'd255; prev_b8 = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run8(ra, rb, ra - rb, (ra < rb));
        end
        for (int i = 0; i < 1000; i++) run16(16'($urandom), 16'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
